// File: rtl/flash_read_arbiter.sv
// Two-requester, one-outstanding-read arbiter in front of the flash core's Avalon-MM read port.
// Define FLASH_ARB_RR_EN for round-robin arbitration; otherwise rq0 has fixed priority over rq1.
module flash_read_arbiter #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        CLOCK_50,
    input  logic        rst_n,
    input  logic        rq0_read,
    input  logic [22:0] rq0_address,
    output logic        rq0_waitrequest,
    output logic [31:0] rq0_readdata,
    output logic        rq0_readdatavalid,
    input  logic        rq1_read,
    input  logic [22:0] rq1_address,
    output logic        rq1_waitrequest,
    output logic [31:0] rq1_readdata,
    output logic        rq1_readdatavalid,
    output logic        flash_mem_read,
    output logic [22:0] flash_mem_address,
    input  logic        flash_mem_waitrequest,
    input  logic [31:0] flash_mem_readdata,
    input  logic        flash_mem_readdatavalid,
    output logic        owner,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} state_t;

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    // Abandon on the cycle the counter would step to TIMEOUT_CYC-1, so the zero word
    // pulses TIMEOUT_CYC cycles after WAIT_DATA is entered.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 2);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               read_q, read_d;
    logic [22:0]        addr_q, addr_d;
    logic               owner_q, owner_d;
    logic               busy_q, busy_d;
    logic               terr_q, terr_d;
    logic [31:0]        rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic               rdv0_q, rdv0_d, rdv1_q, rdv1_d;
    logic               pick0, gnt0, gnt1;

`ifdef FLASH_ARB_RR_EN
    logic last_q, last_d;   // 1 = rq1 was granted last

    // On a contest rq0 wins only if rq1 had the previous grant.
    assign pick0  = (rq0_read && rq1_read) ? last_q : rq0_read;
    assign last_d = gnt1 ? 1'b1 : (gnt0 ? 1'b0 : last_q);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) last_q <= 1'b1;
        else        last_q <= last_d;
    end
`else
    assign pick0 = rq0_read;
`endif

    assign gnt0 = (state_q == IDLE) && pick0;
    assign gnt1 = (state_q == IDLE) && rq1_read && !pick0;

    assign rq0_waitrequest = !gnt0;
    assign rq1_waitrequest = !gnt1;

    always_comb begin
        // NOTE: every signal gets its default first, so no path through the case can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        read_d   = read_q;
        addr_d   = addr_q;
        owner_d  = owner_q;
        terr_d   = terr_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        rdv0_d   = 1'b0;
        rdv1_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    addr_d  = gnt0 ? rq0_address : rq1_address;
                    owner_d = gnt1;
                    read_d  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!flash_mem_waitrequest) begin
                    read_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (flash_mem_readdatavalid || cnt_q == CNT_LAST) begin
                    if (owner_q) begin
                        rdata1_d = flash_mem_readdatavalid ? flash_mem_readdata : 32'h0;
                        rdv1_d   = 1'b1;
                    end else begin
                        rdata0_d = flash_mem_readdatavalid ? flash_mem_readdata : 32'h0;
                        rdv0_d   = 1'b1;
                    end
                    if (!flash_mem_readdatavalid) terr_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            read_q   <= 1'b0;
            addr_q   <= '0;
            owner_q  <= 1'b1;
            busy_q   <= 1'b0;
            terr_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            rdv0_q   <= 1'b0;
            rdv1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            read_q   <= read_d;
            addr_q   <= addr_d;
            owner_q  <= owner_d;
            busy_q   <= busy_d;
            terr_q   <= terr_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            rdv0_q   <= rdv0_d;
            rdv1_q   <= rdv1_d;
        end
    end

    assign flash_mem_read    = read_q;
    assign flash_mem_address = addr_q;
    assign owner             = owner_q;
    assign busy              = busy_q;
    assign timeout_err       = terr_q;
    assign rq0_readdata      = rdata0_q;
    assign rq1_readdata      = rdata1_q;
    assign rq0_readdatavalid = rdv0_q;
    assign rq1_readdatavalid = rdv1_q;

endmodule
